control_state_reg: RTL

CONTROL_STATE_REG -- requirements
Module: control_state_reg

---
 rtl/control_state_reg.sv | 95 +++++++++
 1 files changed

// File: rtl/control_state_reg.sv
// Microsequencer state register with instruction register, status flags,
// fetch stall handling, halt-at-boundary parking and a retired-instruction
// counter. The next microstate comes from an external decoder and is
// registered unfiltered whenever the core is allowed to advance.
module control_state_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  next_state,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  input  logic [3:0]  flags_in,
  input  logic        flags_we,
  input  logic        halt,
  output logic [7:0]  state,
  output logic [15:0] instr,
  output logic [3:0]  status_reg,
  output logic        fetch,
  output logic        halted,
  output logic [15:0] instr_count
);

  // Microstates the block itself needs to recognise; all others pass through.
  localparam logic [7:0] S_IDLE  = 8'h00;
  localparam logic [7:0] S_FETCH = 8'h0F;
  localparam logic [7:0] S_LOAD  = 8'h01;

  logic [7:0]  state_q,       state_d;
  logic [15:0] instr_q,       instr_d;
  logic [3:0]  status_q,      status_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        halted_q,      halted_d;

  logic hold_idle;
  logic advance;
  logic retire;

  // Memory is only being talked to in the fetch and load microstates.
  always_comb begin
    fetch = (state_q == S_FETCH) || (state_q == S_LOAD);
  end

  // Halt only takes effect at the instruction boundary (idle); a memory
  // wait stalls only while a fetch is outstanding, so mem_ready is a
  // don't-care everywhere else.
  assign hold_idle = (state_q == S_IDLE) && halt;
  assign advance   = (!fetch || mem_ready) && !hold_idle;
  // An instruction retires on the edge that returns a busy core to idle.
  assign retire    = advance && (state_q != S_IDLE) && (next_state == S_IDLE);

  // Next-state logic: every register holds unless the core advances.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    status_d      = status_q;
    instr_count_d = instr_count_q;
    halted_d      = hold_idle;
    if (advance) begin
      state_d = next_state;
      if (state_q == S_LOAD) begin
        instr_d = instr_in;
      end
      // Flag writes during a stall or while parked are dropped on purpose.
      if (flags_we) begin
        status_d = flags_in;
      end
      if (retire) begin
        instr_count_d = instr_count_q + 16'd1;
      end
    end
  end

  // State registers; reset aborts any instruction in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      instr_q       <= 16'h0000;
      status_q      <= 4'h0;
      instr_count_q <= 16'h0000;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      status_q      <= status_d;
      instr_count_q <= instr_count_d;
      halted_q      <= halted_d;
    end
  end

  assign state       = state_q;
  assign instr       = instr_q;
  assign status_reg  = status_q;
  assign halted      = halted_q;
  assign instr_count = instr_count_q;

endmodule
